frame_demux_serializer: RTL and testbench
=========================================

// Module: frame_demux_serializer
// PURPOSE
//  Receives a 16-bit framed word stream, validates each frame (header, one-hot channel, CRC-16, trailer),
//  buffers good frames in a small frame FIFO, Gray-codes the payload and shifts it out MSB-first on one of
//  8 serial channels. Sits between the parallel ingress bus and the per-channel serial egress lanes.
// PARAMETERS
//  FIFO_DEPTH  4              good frames buffered (power of 2)
//  MAX_WORDS   8              max payload words per frame (8 x 16 = 128 bits)
//  HEADER      32'hE0E0E0E0   frame header, sent high word first
//  TRAILER     32'h0E0E0E0E   frame trailer, sent high word first
// PORTS
//  clk_in            in   1   single clock; all logic on rising edge
//  rst               in   1   asynchronous reset, active-high
//  data_in           in   16  one stream word sampled every clock (big-endian word order)
//  data_out_ch1..8   out  1   serial Gray-coded payload, MSB first
//  data_vld_ch1..8   out  1   high while corresponding data_out_chN carries a payload bit
//  fifo_empty        out  1   frame FIFO holds no frame
//  fifo_full         out  1   frame FIFO holds FIFO_DEPTH frames
//  crc_valid_o       out  1   1-cycle pulse, coincident with first serial bit of a frame
//  crc_err           out  1   1-cycle pulse, frame with good framing but CRC mismatch
// BEHAVIOUR
//  Reset: async clears FSM to IDLE, FIFO pointers, serializer; all outputs 0 except fifo_empty=1.
//   Reset mid-frame or mid-serialization discards everything; no partial output after release.
//  Frame: HDR_H(E0E0) HDR_L(E0E0) CHAN DATA[1..8] CRC TRL_H(0E0E) TRL_L(0E0E).
//  Parser FSM: IDLE -E0E0-> HDR1 -E0E0-> CHAN -> COLLECT; HDR1 on other word -> IDLE.
//   CHAN word legal only if [15:8]==0 and [7:0] exactly one-hot; else drop, -> IDLE, no crc_err.
//   COLLECT stores words; frame ends when the last two stored words are 0E0E,0E0E; word before = CRC,
//   words between CHAN and CRC = payload, n words, n must be 1..MAX_WORDS.
//   Payload words equal to E0E0 or single 0E0E are ordinary data (no resync inside COLLECT).
//   More than MAX_WORDS+3 words without trailer (oversize) -> silent drop, -> IDLE, no crc_err.
//  CRC: CRC-16 poly 0x1021, init 0x0000, no reflection, no final XOR, over payload words in order,
//   16 bits per step (bit15 first). ex: payload A55A -> CRC 1934.
//  Trailer complete: CRC match -> push {channel, n, payload right-aligned in 128b} to FIFO (dropped if
//   fifo_full, no flag); mismatch -> crc_err=1 on next cycle, nothing pushed. FSM -> IDLE either way.
//  Ingress latency per frame does not stall: next header may follow trailer immediately.
//  Serializer: when idle and FIFO non-empty, pop; first bit driven the following cycle.
//   Gray = P ^ (P >> 1) over L = 16n bits; bits L-1..0 one per clock on selected channel.
//   data_vld_chN high exactly L cycles; crc_valid_o pulses with bit L-1.
//   Unselected channels: data_out=0, data_vld=0. >=1 idle cycle (all vld low) between frames.
//  Simultaneous push and pop in same cycle allowed; fifo_full/empty reflect registered occupancy.
// TESTING
//  ch=0001, data A55A, crc 1934 -> crc_valid_o, ch1 outputs F7F7 MSB-first, vld 16 cycles.
//  ch=0002, 128b 0123456789ABCDEFFEDCBA9876543210 with correct CRC -> ch2 gray of payload, 128 bits.
//  Payload E0E0 on ch3; then CHAN word E0E0 -> first frame output on ch3, second dropped, no crc_err.
//  ch1, data 1234, crc FFFF -> crc_err pulse 1 cycle after trailer, data_vld_ch1 stays 0.
//  Reset asserted 1 cycle right after CRC word / after header -> no output, no crc_err, next frame OK.
//  16-word oversize frame on ch6; then 5 back-to-back random frames -> none for oversize, all 5 correct.

Source files
------------

// File: rtl/frame_demux_serializer.sv
// Framed 16-bit word stream parser with CRC-16 check, frame FIFO and
// per-channel Gray-coded serial egress.
module frame_demux_serializer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WORDS  = 8,
  parameter logic [31:0] HEADER     = 32'hE0E0E0E0,
  parameter logic [31:0] TRAILER    = 32'h0E0E0E0E
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] data_in,
  output logic        data_out_ch1,
  output logic        data_out_ch2,
  output logic        data_out_ch3,
  output logic        data_out_ch4,
  output logic        data_out_ch5,
  output logic        data_out_ch6,
  output logic        data_out_ch7,
  output logic        data_out_ch8,
  output logic        data_vld_ch1,
  output logic        data_vld_ch2,
  output logic        data_vld_ch3,
  output logic        data_vld_ch4,
  output logic        data_vld_ch5,
  output logic        data_vld_ch6,
  output logic        data_vld_ch7,
  output logic        data_vld_ch8,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        crc_valid_o,
  output logic        crc_err
);

  localparam int unsigned PW = MAX_WORDS * 16;
  localparam int unsigned CW = $clog2(MAX_WORDS + 4);
  localparam int unsigned NW = $clog2(MAX_WORDS + 1);
  localparam int unsigned RW = $clog2(PW + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 8 + NW + PW;

  typedef enum logic [1:0] {P_IDLE, P_HDR1, P_CHAN, P_COLLECT} pstate_t;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [15:0] word);
    logic [15:0] c;
    c = crc ^ word;
    for (int unsigned i = 0; i < 16; i++)
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  pstate_t        state, state_next;
  logic           start, store, push, err;
  logic           chan_ok, trailer;
  logic [CW-1:0]  count;
  logic [15:0]    w1, w2;
  logic [15:0]    crc_h0, crc_h1, crc_h2;
  logic [PW-1:0]  pay_sr;
  logic [7:0]     chan;
  logic           crc_err_q;

  logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           pop;
  logic [EW-1:0]  head;
  logic [NW-1:0]  head_n;
  logic [PW-1:0]  head_pay;
  logic [RW-1:0]  rem_load, shamt;

  logic           ser_active, crc_valid_q;
  logic [7:0]     ser_sel;
  logic [PW-1:0]  ser_sr;
  logic [RW-1:0]  ser_rem;
  logic [7:0]     lane_vld, lane_out;

  assign chan_ok = (data_in[15:8] == '0) && $onehot(data_in[7:0]);
  // Trailer is recognised on the word stream itself: last stored word plus the current one.
  assign trailer = (w1 == TRAILER[31:16]) && (data_in == TRAILER[15:0]) && (count != '0);

  // Parser state register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= P_IDLE;
    else     state <= state_next;
  end

  // Parser next-state and per-word control
  always_comb begin
    state_next = state;
    start      = 1'b0;
    store      = 1'b0;
    push       = 1'b0;
    err        = 1'b0;
    case (state)
      P_IDLE:  if (data_in == HEADER[31:16]) state_next = P_HDR1;
      P_HDR1:  state_next = (data_in == HEADER[15:0]) ? P_CHAN : P_IDLE;
      P_CHAN: begin
        if (chan_ok) begin
          state_next = P_COLLECT;
          start      = 1'b1;
        end else begin
          state_next = P_IDLE;
        end
      end
      P_COLLECT: begin
        store = 1'b1;
        if (trailer) begin
          state_next = P_IDLE;
          if (count >= CW'(3)) begin
            if (crc_h2 == w2) push = 1'b1;
            else              err  = 1'b1;
          end
        end else if (count == CW'(MAX_WORDS + 2)) begin
          state_next = P_IDLE;
        end
      end
      default: state_next = P_IDLE;
    endcase
  end

  // Collect datapath: payload lags the stream by two words so CRC and trailer-high never enter it,
  // and the CRC history keeps the value over exactly the payload when the trailer completes.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count     <= '0;
      w1        <= '0;
      w2        <= '0;
      crc_h0    <= '0;
      crc_h1    <= '0;
      crc_h2    <= '0;
      pay_sr    <= '0;
      chan      <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= err;
      if (start) begin
        count  <= '0;
        w1     <= '0;
        w2     <= '0;
        crc_h0 <= '0;
        crc_h1 <= '0;
        crc_h2 <= '0;
        pay_sr <= '0;
        chan   <= data_in[7:0];
      end else if (store) begin
        count  <= count + CW'(1);
        w1     <= data_in;
        w2     <= w1;
        pay_sr <= {pay_sr[PW-17:0], w2};
        crc_h0 <= crc_step(crc_h0, data_in);
        crc_h1 <= crc_h0;
        crc_h2 <= crc_h1;
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH));

  // Frame FIFO storage
  always_ff @(posedge clk_in) begin
    if (push && !fifo_full)
      fifo_mem[wr_ptr[AW-1:0]] <= {chan, NW'(count - CW'(2)), pay_sr};
  end

  // Frame FIFO pointers; a push while full is silently dropped
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !fifo_full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)                rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign head     = fifo_mem[rd_ptr[AW-1:0]];
  assign head_n   = head[PW +: NW];
  assign head_pay = head[PW-1:0];
  assign rem_load = RW'({head_n, 4'b0000});
  assign shamt    = RW'(PW) - rem_load;
  assign pop      = !ser_active && !fifo_empty;

  // Serializer: load Gray code MSB-aligned, then shift one bit per clock
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ser_active  <= 1'b0;
      ser_sel     <= '0;
      ser_sr      <= '0;
      ser_rem     <= '0;
      crc_valid_q <= 1'b0;
    end else if (pop) begin
      ser_active  <= 1'b1;
      ser_sel     <= head[EW-1 -: 8];
      ser_sr      <= (head_pay ^ (head_pay >> 1)) << shamt;
      ser_rem     <= rem_load;
      crc_valid_q <= 1'b1;
    end else begin
      crc_valid_q <= 1'b0;
      if (ser_active) begin
        ser_sr  <= ser_sr << 1;
        ser_rem <= ser_rem - RW'(1);
        if (ser_rem == RW'(1)) ser_active <= 1'b0;
      end
    end
  end

  assign lane_vld = ser_active ? ser_sel : '0;
  assign lane_out = lane_vld & {8{ser_sr[PW-1]}};

  assign data_vld_ch1 = lane_vld[0];
  assign data_vld_ch2 = lane_vld[1];
  assign data_vld_ch3 = lane_vld[2];
  assign data_vld_ch4 = lane_vld[3];
  assign data_vld_ch5 = lane_vld[4];
  assign data_vld_ch6 = lane_vld[5];
  assign data_vld_ch7 = lane_vld[6];
  assign data_vld_ch8 = lane_vld[7];
  assign data_out_ch1 = lane_out[0];
  assign data_out_ch2 = lane_out[1];
  assign data_out_ch3 = lane_out[2];
  assign data_out_ch4 = lane_out[3];
  assign data_out_ch5 = lane_out[4];
  assign data_out_ch6 = lane_out[5];
  assign data_out_ch7 = lane_out[6];
  assign data_out_ch8 = lane_out[7];
  assign crc_valid_o  = crc_valid_q;
  assign crc_err      = crc_err_q;

endmodule

// File: tb/tb_frame_demux_serializer.sv
// Directed bench for frame_demux_serializer with an egress scoreboard.
module tb_frame_demux_serializer;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic data_out_ch1, data_out_ch2, data_out_ch3, data_out_ch4;
  logic data_out_ch5, data_out_ch6, data_out_ch7, data_out_ch8;
  logic data_vld_ch1, data_vld_ch2, data_vld_ch3, data_vld_ch4;
  logic data_vld_ch5, data_vld_ch6, data_vld_ch7, data_vld_ch8;
  logic fifo_empty, fifo_full, crc_valid_o, crc_err;

  frame_demux_serializer #(
    .FIFO_DEPTH(4),
    .MAX_WORDS (8),
    .HEADER    (32'hE0E0E0E0),
    .TRAILER   (32'h0E0E0E0E)
  ) dut (
    .clk_in(clk_in), .rst(rst), .data_in(data_in),
    .data_out_ch1(data_out_ch1), .data_out_ch2(data_out_ch2),
    .data_out_ch3(data_out_ch3), .data_out_ch4(data_out_ch4),
    .data_out_ch5(data_out_ch5), .data_out_ch6(data_out_ch6),
    .data_out_ch7(data_out_ch7), .data_out_ch8(data_out_ch8),
    .data_vld_ch1(data_vld_ch1), .data_vld_ch2(data_vld_ch2),
    .data_vld_ch3(data_vld_ch3), .data_vld_ch4(data_vld_ch4),
    .data_vld_ch5(data_vld_ch5), .data_vld_ch6(data_vld_ch6),
    .data_vld_ch7(data_vld_ch7), .data_vld_ch8(data_vld_ch8),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .crc_valid_o(crc_valid_o), .crc_err(crc_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0]   ch;
    int unsigned  len;
    logic [127:0] gray;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned err_pulses = 0;
  logic        in_frame = 1'b0;

  logic [7:0] vld, dout;
  assign vld  = {data_vld_ch8, data_vld_ch7, data_vld_ch6, data_vld_ch5,
                 data_vld_ch4, data_vld_ch3, data_vld_ch2, data_vld_ch1};
  assign dout = {data_out_ch8, data_out_ch7, data_out_ch6, data_out_ch5,
                 data_out_ch4, data_out_ch3, data_out_ch2, data_out_ch1};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [255:0] p, input int unsigned n);
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 0; i < int'(n); i++) begin
      c = c ^ p[16*(int'(n)-1-i) +: 16];
      for (int b = 0; b < 16; b++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic exp_t mk(input logic [7:0] ch, input int unsigned n, input logic [127:0] p);
    exp_t e;
    e.ch   = ch;
    e.len  = 16 * n;
    e.gray = p ^ (p >> 1);
    return e;
  endfunction

  function automatic logic [15:0] rword();
    logic [15:0] w;
    do w = 16'($urandom); while (w == 16'hE0E0 || w == 16'h0E0E);
    return w;
  endfunction

  task automatic drive(input logic [15:0] w);
    data_in = w;
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] chw, input int unsigned n,
                            input logic [255:0] p, input logic [15:0] crcw);
    drive(16'hE0E0);
    drive(16'hE0E0);
    drive(chw);
    for (int i = 0; i < int'(n); i++) drive(p[16*(int'(n)-1-i) +: 16]);
    drive(crcw);
    drive(16'h0E0E);
    drive(16'h0E0E);
    data_in = 16'h0000;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (sb.size() == 0 && fifo_empty && !in_frame && vld == 8'h00) done = 1'b1;
      else begin
        @(posedge clk_in);
        #1;
      end
    end
    chk(tag, done, 1'b1);
  endtask

  // Egress monitor: collects each serial frame and compares it with the scoreboard head
  initial begin
    logic [7:0]   cur_vld;
    int unsigned  cur_len;
    logic [127:0] cur_bits;
    exp_t         e;
    cur_vld = '0; cur_len = 0; cur_bits = '0;
    forever begin
      @(negedge clk_in);
      if (crc_err) err_pulses++;
      if (rst) begin
        in_frame = 1'b0;
      end else if (vld != 8'h00) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cur_vld  = vld;
          cur_len  = 0;
          cur_bits = '0;
          chk("vld_onehot", $onehot(vld), 1'b1);
          chk("crc_valid_first", crc_valid_o, 1'b1);
        end else begin
          chk("vld_stable", vld, cur_vld);
          chk("crc_valid_mid", crc_valid_o, 1'b0);
        end
        chk("unsel_out_zero", dout & ~vld, 8'h00);
        cur_bits = {cur_bits[126:0], |(dout & vld)};
        cur_len++;
      end else begin
        chk("crc_valid_idle", crc_valid_o, 1'b0);
        if (in_frame) begin
          in_frame = 1'b0;
          chk("frame_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("frame_ch", cur_vld, e.ch);
            chk("frame_len", cur_len, e.len);
            chk("frame_bits", cur_bits, e.gray);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] p;
    logic [15:0]  c;
    int unsigned  n;
    exp_t         e;
    int unsigned  vacc;

    rst = 1'b1;
    data_in = 16'h0000;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_fifo_empty", fifo_empty, 1'b1);
    chk("rst_fifo_full", fifo_full, 1'b0);
    chk("rst_vld", vld, 8'h00);
    chk("rst_out", dout, 8'h00);
    chk("rst_crc_valid", crc_valid_o, 1'b0);
    chk("rst_crc_err", crc_err, 1'b0);
    rst = 1'b0;
    drive(16'h0000);

    // Single-word frame on ch1 with the reference CRC
    e.ch = 8'h01; e.len = 16; e.gray = 128'hF7F7;
    sb.push_back(e);
    send_frame(16'h0001, 1, 256'hA55A, 16'h1934);
    wait_idle("t1_drain");

    // Full 128-bit payload on ch2
    p = 256'h0123456789ABCDEFFEDCBA9876543210;
    sb.push_back(mk(8'h02, 8, p[127:0]));
    send_frame(16'h0002, 8, p, crc_model(p, 8));
    wait_idle("t2_drain");

    // Header-valued payload is plain data; a header-valued channel word drops the frame
    p = 256'hE0E0;
    sb.push_back(mk(8'h04, 1, p[127:0]));
    send_frame(16'h0004, 1, p, crc_model(p, 1));
    send_frame(16'hE0E0, 1, 256'h1111, crc_model(256'h1111, 1));
    wait_idle("t3_drain");
    chk("t3_no_crc_err", err_pulses, 0);

    // Bad CRC: one-cycle crc_err right after the trailer, nothing serialized
    send_frame(16'h0001, 1, 256'h1234, 16'hFFFF);
    chk("t4_crc_err_pulse", crc_err, 1'b1);
    drive(16'h0000);
    chk("t4_crc_err_clear", crc_err, 1'b0);
    vacc = 0;
    for (int i = 0; i < 20; i++) begin
      vacc = vacc | 32'(data_vld_ch1);
      drive(16'h0000);
    end
    chk("t4_vld_ch1_quiet", vacc, 0);
    chk("t4_pulse_count", err_pulses, 1);

    // Reset right after the CRC word
    drive(16'hE0E0); drive(16'hE0E0); drive(16'h0001); drive(16'h5A5A);
    drive(crc_model(256'h5A5A, 1));
    rst = 1'b1;
    drive(16'h0E0E);
    rst = 1'b0;
    drive(16'h0E0E);
    drive(16'h0000);
    chk("t5a_empty", fifo_empty, 1'b1);
    // Reset right after the header
    drive(16'hE0E0); drive(16'hE0E0);
    rst = 1'b1;
    drive(16'h0001);
    rst = 1'b0;
    drive(16'h5A5A); drive(crc_model(256'h5A5A, 1)); drive(16'h0E0E); drive(16'h0E0E);
    drive(16'h0000);
    chk("t5b_empty", fifo_empty, 1'b1);
    chk("t5b_vld", vld, 8'h00);
    p = 256'hBEEF;
    sb.push_back(mk(8'h80, 1, p[127:0]));
    send_frame(16'h0080, 1, p, crc_model(p, 1));
    wait_idle("t5_drain");
    chk("t5_no_crc_err", err_pulses, 1);

    // Oversize frame, then back-to-back frames that fill the FIFO, then one that overflows
    p = '0;
    for (int i = 0; i < 16; i++) p[16*i +: 16] = rword();
    send_frame(16'h0020, 16, p, crc_model(p, 16));
    for (int f = 0; f < 6; f++) begin
      n = (f == 0) ? 8 : $urandom_range(1, 8);
      do begin
        p = '0;
        for (int i = 0; i < int'(n); i++) p[16*i +: 16] = rword();
        c = crc_model(p, n);
      end while (c == 16'h0E0E);
      if (f < 5) sb.push_back(mk(8'h01 << (f % 8), n, p[127:0]));
      send_frame(16'(8'h01 << (f % 8)), n, p, c);
      if (f == 4) chk("t6_fifo_full", fifo_full, 1'b1);
    end
    chk("t6_fifo_full_after_drop", fifo_full, 1'b1);
    wait_idle("t6_drain");
    chk("t6_no_crc_err", err_pulses, 1);
    chk("end_fifo_empty", fifo_empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
